// File: rtl/imm_extend_unit_pkg.sv
// Shared types and defaults for the immediate generator.
// Mode encodings, FSM states and default widths.
package imm_extend_unit_pkg;

    localparam int IMM_W_DEF     = 12;
    localparam int DATA_W_DEF    = 16;
    localparam int SHIFT_AMT_DEF = 1;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_SHIFT = 2'd2,
        IMM_UPPER = 2'd3
    } imm_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_PREFIX = 1'b1
    } state_e;

endpackage

// File: rtl/imm_extend_unit_core.sv
// Combinational extension of a single or prefixed raw immediate.
// Ports: hi/lo immediate words, pair (use {hi,lo}), mode, ext result.
module imm_extend_core
    import imm_extend_unit_pkg::*;
#(
    parameter int IMMEDIATE_WIDTH = IMM_W_DEF,
    parameter int DATA_BUS_WIDTH  = DATA_W_DEF,
    parameter int SHIFT_AMT       = SHIFT_AMT_DEF
) (
    input  logic [IMMEDIATE_WIDTH-1:0] hi,
    input  logic [IMMEDIATE_WIDTH-1:0] lo,
    input  logic                       pair,
    input  imm_mode_e                  mode,
    output logic [DATA_BUS_WIDTH-1:0]  ext
);

    localparam int IW = IMMEDIATE_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;
    localparam int W2 = 2 * IW;
    localparam int UP1 = DW - IW;
    // A prefixed raw wider than the bus is truncated, not placed.
    localparam int UP2 = (W2 > DW) ? 0 : DW - W2;

    logic [W2-1:0] raw2;
    logic [DW-1:0] sx;
    logic [DW-1:0] zx;
    logic [DW-1:0] up;

    assign raw2 = {hi, lo};

    // Size casts of signed values sign-extend, or truncate when
    // the raw value is wider than the bus.
    always_comb begin
        if (pair) begin
            sx = DW'($signed(raw2));
            zx = DW'(raw2);
            up = DW'(raw2) << UP2;
        end else begin
            sx = DW'($signed(lo));
            zx = DW'(lo);
            up = DW'(lo) << UP1;
        end
    end

    always_comb begin
        ext = sx;
        unique case (mode)
            IMM_SIGN:  ext = sx;
            IMM_ZERO:  ext = zx;
            IMM_SHIFT: ext = sx << SHIFT_AMT;
            IMM_UPPER: ext = up;
            default:   ext = sx;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate generator with two-word prefix support.
// Ports: clk, rst_n, load/src/mode/prefix/flush in; imm_out, imm_valid, prefix_pending out.
module imm_extend_unit
    import imm_extend_unit_pkg::*;
#(
    parameter int IMMEDIATE_WIDTH = IMM_W_DEF,
    parameter int DATA_BUS_WIDTH  = DATA_W_DEF,
    parameter int SHIFT_AMT       = SHIFT_AMT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [IMMEDIATE_WIDTH-1:0] src,
    input  logic [1:0]                 mode,
    input  logic                       prefix,
    input  logic                       flush,
    output logic [DATA_BUS_WIDTH-1:0]  imm_out,
    output logic                       imm_valid,
    output logic                       prefix_pending
);

    state_e                     state;
    state_e                     state_nx;
    logic [IMMEDIATE_WIDTH-1:0] prefix_reg;
    logic [IMMEDIATE_WIDTH-1:0] prefix_nx;
    logic                       do_op;
    logic                       pair;
    logic [IMMEDIATE_WIDTH-1:0] hi;
    logic [DATA_BUS_WIDTH-1:0]  ext;

    imm_extend_core #(
        .IMMEDIATE_WIDTH (IMMEDIATE_WIDTH),
        .DATA_BUS_WIDTH  (DATA_BUS_WIDTH),
        .SHIFT_AMT       (SHIFT_AMT)
    ) u_core (
        .hi   (hi),
        .lo   (src),
        .pair (pair),
        .mode (imm_mode_e'(mode)),
        .ext  (ext)
    );

    // Flush is applied before the load, so a same-cycle load
    // always starts from IDLE with an empty prefix.
    always_comb begin
        state_nx  = state;
        prefix_nx = prefix_reg;
        do_op     = 1'b0;
        pair      = 1'b0;
        hi        = prefix_reg;
        if (flush) begin
            state_nx  = ST_IDLE;
            prefix_nx = '0;
        end
        if (load) begin
            if (prefix) begin
                state_nx  = ST_PREFIX;
                prefix_nx = src;
            end else begin
                do_op    = 1'b1;
                pair     = (state == ST_PREFIX) && !flush;
                state_nx = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            prefix_reg <= '0;
            imm_out    <= '0;
            imm_valid  <= 1'b0;
        end else begin
            state      <= state_nx;
            prefix_reg <= prefix_nx;
            imm_valid  <= do_op;
            if (do_op) begin
                imm_out <= ext;
            end
        end
    end

    assign prefix_pending = (state == ST_PREFIX);

endmodule
